sshooter_sound_mailbox: RTL and testbench

Sound-command mailbox and Z80 interrupt sequencer between the main MC6809E and the sound Z80. It replaces the bare sound latch and IRQ flip-flop with a small command FIFO, so back-to-back writes from the main CPU are delivered in order. The FIFO head is presented to the Z80, which is interrupted once per command; the next command is released only after the Z80 acknowledges the interrupt and reads the data. It sits between the main CPU's I/O decode (sound-latch write select) and the Z80 data-input multiplexer and INT_n pin.

---
 rtl/sshooter_sound_mailbox.sv | 204 ++++++++++++++++++++
 tb/tb_sshooter_sound_mailbox.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sshooter_sound_mailbox.sv
// Sound-command mailbox between the main 6809 and the sound Z80.
// Commands written by the main CPU are queued in a small FIFO. The head is
// presented to the Z80 one command at a time. Each command raises INT_n, and
// the next command is released only after the Z80 acknowledges and reads.
module sshooter_sound_mailbox #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INT_TIMEOUT = 0
) (
    input  logic       clk_49m,
    input  logic       reset,
    input  logic       cen_3m,
    input  logic       n_cen_3m,
    input  logic       cs_soundlatch,
    input  logic [7:0] din,
    input  logic       z80_n_m1,
    input  logic       z80_n_iorq,
    input  logic       sounddata_rd,
    output logic [7:0] sound_data,
    output logic       z80_n_int,
    output logic [4:0] pending,
    output logic       busy,
    output logic [7:0] ovf_cnt
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned TO_W   = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(INT_TIMEOUT);
    localparam logic              TO_EN    = (INT_TIMEOUT != 0);
    localparam logic [DATA_W-1:0] OVF_MAX  = DATA_W'(255);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_READ = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               rd_q;
    logic               rd_seen;
    logic               rd_seen_d;
    logic [TO_W-1:0]    to_cnt;
    logic [TO_W-1:0]    to_cnt_d;

    logic               push_c;
    logic               pop_c;
    logic               release_c;
    logic               rd_rise_c;
    logic               ack_c;
    logic               timeout_c;
    logic               full_c;
    logic               overwrite_c;
    logic               write_c;
    logic [PTR_W-1:0]   wr_addr_c;
    logic [PTR_W-1:0]   wr_ptr_inc_c;
    logic [PTR_W-1:0]   wr_ptr_dec_c;
    logic [PTR_W-1:0]   rd_ptr_inc_c;

    // Input qualifiers: push strobe, read-strobe rising edge, interrupt acknowledge
    always_comb begin
        push_c    = cen_3m & cs_soundlatch;
        rd_rise_c = sounddata_rd & ~rd_q;
        ack_c     = ~z80_n_m1 & ~z80_n_iorq;
    end

    // Pointer arithmetic wrapping modulo DEPTH
    always_comb begin
        wr_ptr_inc_c = (wr_ptr == PTR_LAST) ? '0 : PTR_W'(wr_ptr + 1'b1);
        wr_ptr_dec_c = (wr_ptr == '0) ? PTR_LAST : PTR_W'(wr_ptr - 1'b1);
        rd_ptr_inc_c = (rd_ptr == PTR_LAST) ? '0 : PTR_W'(rd_ptr + 1'b1);
    end

    // Full-queue policy: a push with no room replaces the newest entry.
    // A simultaneous pop frees a slot, so that push is an ordinary append.
    always_comb begin
        full_c      = (pending == DEPTH_C);
        overwrite_c = push_c & full_c & ~pop_c;
        write_c     = push_c & ~overwrite_c;
        wr_addr_c   = overwrite_c ? wr_ptr_dec_c : wr_ptr;
    end

    // Interrupt sequencer state register
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rd_seen <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            rd_seen <= rd_seen_d;
            to_cnt  <= to_cnt_d;
        end
    end

    // Interrupt sequencer next state, pop and release strobes
    always_comb begin
        state_d   = state_q;
        rd_seen_d = rd_seen;
        to_cnt_d  = to_cnt;
        pop_c     = 1'b0;
        release_c = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (n_cen_3m && (pending != '0)) begin
                    pop_c   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rd_rise_c) begin
                    rd_seen_d = 1'b1;
                end
                if (n_cen_3m) begin
                    to_cnt_d = TO_W'(to_cnt + 1'b1);
                end
                timeout_c = TO_EN && n_cen_3m && (TO_W'(to_cnt + 1'b1) == TO_LIMIT);
                if (ack_c || timeout_c) begin
                    release_c = 1'b1;
                    to_cnt_d  = '0;
                    // A read seen while still interrupted completes the handshake
                    state_d   = (rd_seen || rd_rise_c) ? IDLE : WAIT_READ;
                end
            end
            WAIT_READ: begin
                if (rd_rise_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d == IDLE) begin
            rd_seen_d = 1'b0;
        end
    end

    // Command storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk_49m) begin
        if (push_c) begin
            mem[wr_addr_c] <= din;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (write_c) begin
                wr_ptr <= wr_ptr_inc_c;
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr_inc_c;
            end
            case ({write_c, pop_c})
                2'b10:   pending <= CNT_W'(pending + 1'b1);
                2'b01:   pending <= CNT_W'(pending - 1'b1);
                default: pending <= pending;
            endcase
        end
    end

    // Saturating count of commands lost to overwrite
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            ovf_cnt <= '0;
        end else if (overwrite_c && (ovf_cnt != OVF_MAX)) begin
            ovf_cnt <= DATA_W'(ovf_cnt + 1'b1);
        end
    end

    // Z80-facing outputs: latched command, INT_n, busy flag, read-strobe history
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            sound_data <= '0;
            z80_n_int  <= 1'b1;
            busy       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            rd_q <= sounddata_rd;
            busy <= (state_d != IDLE);
            if (pop_c) begin
                sound_data <= mem[rd_ptr];
                z80_n_int  <= 1'b0;
            end else if (release_c) begin
                z80_n_int  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sshooter_sound_mailbox.sv
// Directed bench for the sound-command mailbox. Two instances share stimulus:
// dut_a with no interrupt timeout, dut_b with an 8-pulse timeout.
module tb_sshooter_sound_mailbox;

    logic       clk_49m = 1'b0;
    logic       reset;
    logic       cen_3m;
    logic       n_cen_3m;
    logic       cs_soundlatch;
    logic [7:0] din;
    logic       z80_n_m1;
    logic       z80_n_iorq;
    logic       sounddata_rd;

    logic [7:0] sd_a, sd_b;
    logic       int_a, int_b;
    logic [4:0] pend_a, pend_b;
    logic       busy_a, busy_b;
    logic [7:0] ovf_a, ovf_b;

    int         total = 0;
    int         bad = 0;
    logic [3:0] phase = 4'd0;

    always #10 clk_49m = ~clk_49m;

    sshooter_sound_mailbox #(.DEPTH(4), .INT_TIMEOUT(0)) dut_a (
        .clk_49m(clk_49m), .reset(reset), .cen_3m(cen_3m), .n_cen_3m(n_cen_3m),
        .cs_soundlatch(cs_soundlatch), .din(din), .z80_n_m1(z80_n_m1),
        .z80_n_iorq(z80_n_iorq), .sounddata_rd(sounddata_rd),
        .sound_data(sd_a), .z80_n_int(int_a), .pending(pend_a),
        .busy(busy_a), .ovf_cnt(ovf_a)
    );

    sshooter_sound_mailbox #(.DEPTH(4), .INT_TIMEOUT(8)) dut_b (
        .clk_49m(clk_49m), .reset(reset), .cen_3m(cen_3m), .n_cen_3m(n_cen_3m),
        .cs_soundlatch(cs_soundlatch), .din(din), .z80_n_m1(z80_n_m1),
        .z80_n_iorq(z80_n_iorq), .sounddata_rd(sounddata_rd),
        .sound_data(sd_b), .z80_n_int(int_b), .pending(pend_b),
        .busy(busy_b), .ovf_cnt(ovf_b)
    );

    // One clock; inputs change and outputs are sampled 1 ns after the edge.
    // The enables form a divide-by-16 pair, cen_3m at phase 0, n_cen_3m at phase 8.
    task automatic step();
        @(posedge clk_49m);
        #1;
        phase    = phase + 4'd1;
        cen_3m   = (phase == 4'd0);
        n_cen_3m = (phase == 4'd8);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic push(input logic [7:0] v);
        int guard;
        guard = 0;
        while (!cen_3m && guard < 40) begin
            step();
            guard++;
        end
        cs_soundlatch = 1'b1;
        din = v;
        step();
        cs_soundlatch = 1'b0;
    endtask

    task automatic ack();
        z80_n_m1 = 1'b0;
        z80_n_iorq = 1'b0;
        step();
        z80_n_m1 = 1'b1;
        z80_n_iorq = 1'b1;
    endtask

    task automatic rd_pulse();
        sounddata_rd = 1'b1;
        step();
        sounddata_rd = 1'b0;
        step();
    endtask

    // Steps until the selected instance drives INT_n low; n=41 means it never did
    task automatic wait_int(input bit sel_b, output int n);
        n = 0;
        while (((sel_b ? int_b : int_a) !== 1'b0) && n <= 40) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sd_a !== 8'h00) begin bad++; $display("FAIL reset_sound_data got=%h exp=00", sd_a); end
        total++; if (int_a !== 1'b1) begin bad++; $display("FAIL reset_int got=%b exp=1", int_a); end
        total++; if (pend_a !== 5'd0) begin bad++; $display("FAIL reset_pending got=%0d exp=0", pend_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (ovf_a !== 8'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", ovf_a); end
        total++; if (int_b !== 1'b1) begin bad++; $display("FAIL reset_int_b got=%b exp=1", int_b); end
    endtask

    task automatic test_single();
        int n;
        do_reset();
        push(8'h5A);
        total++; if (pend_a !== 5'd1) begin bad++; $display("FAIL single_push_pending got=%0d exp=1", pend_a); end
        wait_int(1'b0, n);
        total++; if (n > 16) begin bad++; $display("FAIL single_int_latency got=%0d exp<=16", n); end
        total++; if (sd_a !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", sd_a); end
        total++; if (pend_a !== 5'd0) begin bad++; $display("FAIL single_pop_pending got=%0d exp=0", pend_a); end
        ack();
        total++; if (int_a !== 1'b1) begin bad++; $display("FAIL single_ack_int got=%b exp=1", int_a); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL single_ack_busy got=%b exp=1", busy_a); end
        rd_pulse();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL single_read_busy got=%b exp=0", busy_a); end
        total++; if (sd_a !== 8'h5A) begin bad++; $display("FAIL single_hold_data got=%h exp=5a", sd_a); end
    endtask

    task automatic test_burst();
        int n;
        logic [7:0] exp_v;
        do_reset();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        push(8'h04);
        total++; if (pend_a !== 5'd3) begin bad++; $display("FAIL burst_pending got=%0d exp=3", pend_a); end
        total++; if (sd_a !== 8'h01) begin bad++; $display("FAIL burst_head got=%h exp=01", sd_a); end
        total++; if (int_a !== 1'b0) begin bad++; $display("FAIL burst_int got=%b exp=0", int_a); end
        for (int i = 0; i < 32; i++) step();
        total++; if (sd_a !== 8'h01) begin bad++; $display("FAIL burst_hold got=%h exp=01", sd_a); end
        total++; if (pend_a !== 5'd3) begin bad++; $display("FAIL burst_no_pop got=%0d exp=3", pend_a); end
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'(i + 1);
            if (i > 0) begin
                wait_int(1'b0, n);
                total++; if (n > 16) begin bad++; $display("FAIL burst_int_%0d got=%0d exp<=16", i, n); end
            end
            total++; if (sd_a !== exp_v) begin bad++; $display("FAIL burst_order_%0d got=%h exp=%h", i, sd_a, exp_v); end
            ack();
            rd_pulse();
        end
        total++; if (pend_a !== 5'd0) begin bad++; $display("FAIL burst_drained got=%0d exp=0", pend_a); end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h16;
        do_reset();
        push(8'hEE);
        wait_int(1'b0, n);
        for (int i = 0; i < 6; i++) push(8'(8'h11 + i));
        total++; if (pend_a !== 5'd4) begin bad++; $display("FAIL ovf_pending got=%0d exp=4", pend_a); end
        total++; if (ovf_a !== 8'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", ovf_a); end
        total++; if (sd_a !== 8'hEE) begin bad++; $display("FAIL ovf_head got=%h exp=ee", sd_a); end
        ack();
        rd_pulse();
        for (int i = 0; i < 4; i++) begin
            wait_int(1'b0, n);
            total++; if (n > 16) begin bad++; $display("FAIL ovf_int_%0d got=%0d exp<=16", i, n); end
            total++; if (sd_a !== exp_q[i]) begin bad++; $display("FAIL ovf_order_%0d got=%h exp=%h", i, sd_a, exp_q[i]); end
            ack();
            rd_pulse();
        end
        total++; if (ovf_a !== 8'd2) begin bad++; $display("FAIL ovf_final got=%0d exp=2", ovf_a); end
    endtask

    task automatic test_rd_before_ack();
        int n;
        do_reset();
        push(8'hA1);
        wait_int(1'b0, n);
        push(8'hA2);
        rd_pulse();
        total++; if (int_a !== 1'b0) begin bad++; $display("FAIL rba_int_held got=%b exp=0", int_a); end
        ack();
        total++; if (int_a !== 1'b1) begin bad++; $display("FAIL rba_ack_int got=%b exp=1", int_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rba_to_idle got=%b exp=0", busy_a); end
        wait_int(1'b0, n);
        total++; if (n > 16) begin bad++; $display("FAIL rba_next_int got=%0d exp<=16", n); end
        total++; if (sd_a !== 8'hA2) begin bad++; $display("FAIL rba_next_data got=%h exp=a2", sd_a); end
        ack();
        rd_pulse();
    endtask

    task automatic test_timeout();
        int n;
        int pulses;
        int guard;
        do_reset();
        push(8'hB1);
        wait_int(1'b1, n);
        total++; if (sd_b !== 8'hB1) begin bad++; $display("FAIL to_data got=%h exp=b1", sd_b); end
        pulses = 0;
        guard = 0;
        while (int_b !== 1'b1 && guard < 400) begin
            if (n_cen_3m) pulses++;
            step();
            guard++;
        end
        total++; if (pulses != 8) begin bad++; $display("FAIL to_pulses got=%0d exp=8", pulses); end
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL to_wait_read got=%b exp=1", busy_b); end
        total++; if (int_a !== 1'b0) begin bad++; $display("FAIL to_disabled_int got=%b exp=0", int_a); end
        push(8'hB2);
        push(8'hB3);
        total++; if (pend_b !== 5'd2) begin bad++; $display("FAIL to_queued got=%0d exp=2", pend_b); end
        rd_pulse();
        total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL to_read_idle got=%b exp=0", busy_b); end
        guard = 0;
        while (!n_cen_3m && guard < 40) begin
            step();
            guard++;
        end
        cen_3m = 1'b1;
        cs_soundlatch = 1'b1;
        din = 8'hB4;
        step();
        cs_soundlatch = 1'b0;
        total++; if (pend_b !== 5'd2) begin bad++; $display("FAIL to_push_pop_pending got=%0d exp=2", pend_b); end
        total++; if (sd_b !== 8'hB2) begin bad++; $display("FAIL to_push_pop_data got=%h exp=b2", sd_b); end
        ack();
        rd_pulse();
        wait_int(1'b1, n);
        total++; if (sd_b !== 8'hB3) begin bad++; $display("FAIL to_next_b3 got=%h exp=b3", sd_b); end
        ack();
        rd_pulse();
        wait_int(1'b1, n);
        total++; if (sd_b !== 8'hB4) begin bad++; $display("FAIL to_next_b4 got=%h exp=b4", sd_b); end
        total++; if (pend_b !== 5'd0) begin bad++; $display("FAIL to_drained got=%0d exp=0", pend_b); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        push(8'hC1);
        wait_int(1'b0, n);
        for (int i = 0; i < 5; i++) push(8'(8'hC2 + i));
        total++; if (ovf_a !== 8'd1) begin bad++; $display("FAIL rst_pre_ovf got=%0d exp=1", ovf_a); end
        total++; if (int_a !== 1'b0) begin bad++; $display("FAIL rst_pre_int got=%b exp=0", int_a); end
        #5;
        reset = 1'b0;
        #1;
        total++; if (int_a !== 1'b1) begin bad++; $display("FAIL rst_async_int got=%b exp=1", int_a); end
        total++; if (pend_a !== 5'd0) begin bad++; $display("FAIL rst_pending got=%0d exp=0", pend_a); end
        total++; if (ovf_a !== 8'd0) begin bad++; $display("FAIL rst_ovf got=%0d exp=0", ovf_a); end
        total++; if (sd_a !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", sd_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        total++; if (int_a !== 1'b1) begin bad++; $display("FAIL rst_queue_gone got=%b exp=1", int_a); end
    endtask

    initial begin
        reset = 1'b0;
        cen_3m = 1'b0;
        n_cen_3m = 1'b0;
        cs_soundlatch = 1'b0;
        din = 8'h00;
        z80_n_m1 = 1'b1;
        z80_n_iorq = 1'b1;
        sounddata_rd = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_rd_before_ack();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
